rev_seq_divider: RTL



---
 rtl/rev_alu_pkg.sv | 17 +
 rtl/rev_trial_sub.sv | 26 ++
 rtl/rev_seq_divider.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rev_alu_pkg.sv
// Shared definitions for the reversible ALU slice: default widths, divider FSM states.
package rev_alu_pkg;

    localparam int unsigned DEF_DW = 4;
    localparam int unsigned DEF_VW = 2;
    localparam int unsigned CNT_W  = $clog2(DEF_DW + 1);

    // Quotient reported for a zero divisor at the default width
    localparam logic [DEF_DW-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/rev_trial_sub.sv
// Combinational ripple subtractor built from reversible full-subtractor cells.
module rev_trial_sub #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] minuend,
    input  logic [W-1:0] subtrahend,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] bw;

    assign bw[0] = 1'b0;

    // One cell per bit: a Peres-gate pair yielding a^b^bin and the borrow-out;
    // the cell's garbage lines are not brought out of the chain.
    for (genvar i = 0; i < W; i++) begin : g_cell
        logic t;
        assign t         = minuend[i] ^ subtrahend[i];
        assign diff[i]   = t ^ bw[i];
        assign bw[i + 1] = (~minuend[i] & subtrahend[i]) | (~t & bw[i]);
    end

    assign borrow = bw[W];

endmodule

// File: rtl/rev_seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
module rev_seq_divider
    import rev_alu_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned VW = DEF_VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int unsigned CW = $clog2(DW + 1);

    div_state_e    state, state_next;
    logic [DW-1:0] dvd_sh;
    logic [DW-1:0] q_sh;
    logic [VW-1:0] dvs;
    logic [VW:0]   p;
    logic [CW-1:0] cnt;

    logic          accept_c;
    logic          zero_c;
    logic          last_c;
    logic [VW:0]   p_shift_c;
    logic [VW:0]   diff_c;
    logic          borrow_c;
    logic [VW:0]   p_next_c;
    logic [DW-1:0] q_next_c;

    // Trial subtraction of the divisor from the shifted partial remainder
    assign p_shift_c = {p[VW-1:0], dvd_sh[DW-1]};

    rev_trial_sub #(
        .W(VW + 1)
    ) u_trial_sub (
        .minuend   (p_shift_c),
        .subtrahend({1'b0, dvs}),
        .diff      (diff_c),
        .borrow    (borrow_c)
    );

    assign p_next_c = borrow_c ? p_shift_c : diff_c;
    assign q_next_c = {q_sh[DW-2:0], ~borrow_c};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DONE accepts a new start just like IDLE
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        zero_c     = (divisor == '0);
        last_c     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = zero_c ? DONE : RUN;
                end
            end
            RUN: begin
                last_c = (cnt == CW'(1));
                if (last_c) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = zero_c ? DONE : RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath, iteration counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            dvd_sh      <= '0;
            q_sh        <= '0;
            dvs         <= '0;
            p           <= '0;
            cnt         <= '0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            if (accept_c && !zero_c) begin
                dvd_sh <= dividend;
                dvs    <= divisor;
                p      <= '0;
                q_sh   <= '0;
                cnt    <= CW'(DW);
            end else if (accept_c) begin
                quotient    <= '1;
                remainder   <= '0;
                div_by_zero <= 1'b1;
            end else if (state == RUN) begin
                p      <= p_next_c;
                dvd_sh <= {dvd_sh[DW-2:0], 1'b0};
                q_sh   <= q_next_c;
                cnt    <= cnt - CW'(1);
                if (last_c) begin
                    quotient    <= q_next_c;
                    remainder   <= p_next_c[VW-1:0];
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule
